// File: rtl/joy_db15_tx.sv
// DB15 joystick serial transmitter: latches two 12-bit pads on a host load strobe and shifts them out on host clock edges.
// Optional define JOY_DB15_TX_GLITCH_FILTER_EN adds a 3-sample majority filter on the synchronized host clock.
module joy_db15_tx #(
  parameter int SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [11:0] joystick1,
  input  logic [11:0] joystick2,
  input  logic        joy_clk,
  input  logic        joy_load,
  output logic        joy_data,
  output logic        frame_done,
  output logic        overrun
);

  typedef enum logic [1:0] {IDLE, LOAD, SHIFT, DONE} state_t;

  state_t                 state_reg, state_next;
  logic [SYNC_STAGES-1:0] clk_sync_reg, load_sync_reg;
  logic [23:0]            shift_reg, shift_next;
  logic [4:0]             cnt_reg, cnt_next;
  logic                   overrun_reg, overrun_next;
  logic                   frame_done_reg, frame_done_next;
  logic                   clk_prev_reg;
  logic                   clk_s, load_s, clk_filt, clk_edge;

  assign clk_s  = clk_sync_reg[SYNC_STAGES-1];
  assign load_s = load_sync_reg[SYNC_STAGES-1];

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      clk_sync_reg  <= '1;
      load_sync_reg <= '1;
    end else begin
      clk_sync_reg  <= {clk_sync_reg[SYNC_STAGES-2:0], joy_clk};
      load_sync_reg <= {load_sync_reg[SYNC_STAGES-2:0], joy_load};
    end
  end

`ifdef JOY_DB15_TX_GLITCH_FILTER_EN
  // A single-clk pulse only ever occupies one history slot, so the majority never sees it.
  logic [2:0] clk_hist_reg;

  always_ff @(posedge clk) begin
    if (!reset_n) clk_hist_reg <= 3'b111;
    else          clk_hist_reg <= {clk_hist_reg[1:0], clk_s};
  end

  assign clk_filt = (clk_hist_reg[0] & clk_hist_reg[1]) |
                    (clk_hist_reg[0] & clk_hist_reg[2]) |
                    (clk_hist_reg[1] & clk_hist_reg[2]);
`else
  assign clk_filt = clk_s;
`endif

  always_ff @(posedge clk) begin
    if (!reset_n) clk_prev_reg <= 1'b1;
    else          clk_prev_reg <= clk_filt;
  end

  assign clk_edge = clk_filt & ~clk_prev_reg;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_reg      <= IDLE;
      shift_reg      <= '1;
      cnt_reg        <= '0;
      overrun_reg    <= 1'b0;
      frame_done_reg <= 1'b0;
    end else begin
      state_reg      <= state_next;
      shift_reg      <= shift_next;
      cnt_reg        <= cnt_next;
      overrun_reg    <= overrun_next;
      frame_done_reg <= frame_done_next;
    end
  end

  // Load strobe has priority over everything, including a coincident clock edge.
  always_comb begin
    state_next      = state_reg;
    shift_next      = shift_reg;
    cnt_next        = cnt_reg;
    overrun_next    = overrun_reg;
    frame_done_next = 1'b0;
    if (!load_s) begin
      state_next   = LOAD;
      shift_next   = ~{joystick2, joystick1};
      cnt_next     = '0;
      overrun_next = 1'b0;
    end else begin
      case (state_reg)
        LOAD:  state_next = SHIFT;
        SHIFT: begin
          if (clk_edge) begin
            shift_next = {1'b1, shift_reg[23:1]};
            cnt_next   = cnt_reg + 5'd1;
            if (cnt_reg == 5'd23) begin
              state_next      = DONE;
              frame_done_next = 1'b1;
            end
          end
        end
        DONE:    if (clk_edge) overrun_next = 1'b1;
        default: state_next = IDLE;
      endcase
    end
  end

  always_comb begin
    joy_data = 1'b1;
    case (state_reg)
      LOAD:    joy_data = ~joystick1[0];
      SHIFT:   joy_data = shift_reg[0];
      default: joy_data = 1'b1;
    endcase
  end

  assign frame_done = frame_done_reg;
  assign overrun    = overrun_reg;

endmodule

// File: doc/joy_db15_tx.md
JOY_DB15_TX -- requirements
Module: joy_db15_tx

Interface
REQ-001 SHALL have parameter SYNC_STAGES, default 2: number of synchronizer flops on joy_clk and joy_load; legal range 2-3.
REQ-002 SHALL have port clk, input, 1: system clock, 40-50 MHz; the only clock.
REQ-003 SHALL have port reset_n, input, 1: reset, synchronous, active-low.
REQ-004 SHALL have port joystick1, input, 12: player-1 state, active-high, format ----LS FEDCBAUDLR (bit0=R … bit11=L-shoulder/select).
REQ-005 SHALL have port joystick2, input, 12: player-2 state, same format.
REQ-006 SHALL have port joy_clk, input, 1: host shift clock, asynchronous to clk.
REQ-007 SHALL have port joy_load, input, 1: host latch strobe, asynchronous, active-low.
REQ-008 SHALL have port joy_data, output, 1: serial data to host, active-low buttons.
REQ-009 SHALL have port frame_done, output, 1: one-clk pulse after the 24th bit is shifted out.
REQ-010 SHALL have port overrun, output, 1: sticky flag, host clocked beyond 24 bits in the current frame.

Function
REQ-011 SHALL pass joy_clk and joy_load each through SYNC_STAGES flops; rising-edge detect on synchronized joy_clk.
REQ-012 SHALL implement states IDLE, LOAD, SHIFT, DONE.
REQ-013 While synchronized joy_load=0: state LOAD; 24-bit shift register loaded every clk with ~{joystick2, joystick1}; bit counter cleared; joy_data = ~joystick1[0] as of that cycle.
REQ-014 LOAD->SHIFT on synchronized joy_load 0->1; joy_data presents bit 0 (P1 R) before the first joy_clk edge.
REQ-015 In SHIFT, each joy_clk rising edge shifts right one bit, increments the 5-bit counter; joy_data = shift_reg[0]; order is P1 bit0..11, then P2 bit0..11.
REQ-016 On the edge where the counter reaches 24: SHIFT->DONE, frame_done=1 for exactly one clk, joy_data=1.
REQ-017 In DONE, each further joy_clk edge sets overrun=1; joy_data stays 1; counter saturates at 24 (no wrap).
REQ-018 joy_load=0 in any state SHALL abort and go to LOAD immediately; load wins over a coincident joy_clk edge; overrun cleared on entry to LOAD.
REQ-019 joy_clk edges in IDLE SHALL be ignored; joy_data=1 in IDLE.
REQ-020 Joystick inputs SHALL be sampled only in LOAD; changes during SHIFT/DONE SHALL not affect the current frame.
REQ-021 Output latency: joy_data SHALL update SYNC_STAGES+1 clk after the joy_clk edge at the pin.

Reset
REQ-022 On reset_n=0 at a clk edge: state IDLE, shift register all ones, counter 0, synchronizers to 1, joy_data=1, frame_done=0, overrun=0.
REQ-023 Reset asserted mid-SHIFT SHALL discard the frame; after release, no shift occurs until a new joy_load low pulse.

Configuration
REQ-024 Macro JOY_DB15_TX_GLITCH_FILTER_EN defined: synchronized joy_clk SHALL pass a 3-sample majority filter before edge detect (+2 clk latency); pulses of 1 clk width are rejected.
REQ-025 Macro undefined: no filter; every synchronized 0->1 transition counts as an edge; latency per REQ-021.

Verification
REQ-026 joystick1=12'h011, joystick2=12'h800, load pulse, 24 clocks at 1 MHz -> serial stream (wire level) 0,1,1,1,0,1×18,0; frame_done pulses once.
REQ-027 Full frame plus 3 extra joy_clk edges -> joy_data=1 on extras, overrun=1, counter holds at 24; next load pulse clears overrun.
REQ-028 joy_load low after 10 edges -> counter 0, next frame restarts at P1 bit0; no frame_done for the aborted frame.
REQ-029 joy_load rising and joy_clk rising in same synchronized cycle -> no shift; bit0 still presented.
REQ-030 reset_n=0 for one clk after 5 edges -> joy_data=1, outputs cleared; 20 following joy_clk edges without load -> joy_data stays 1, no frame_done.
REQ-031 With JOY_DB15_TX_GLITCH_FILTER_EN: single-clk glitch on joy_clk mid-frame -> no shift; without the macro -> one extra shift.
